// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : Fetch stage for the pr3 single-cycle processor. Holds the
//            instruction memory, maintains the program counter and offers one
//            instruction at a time over a valid/ready handshake. Accepts PC
//            redirects from the consumer and flags when the loaded program
//            has been fully issued.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   MEM_DEPTH      : number of 32-bit words in iMem
//   NUM_INSTR      : number of valid program words loaded from word 0
//                    (NUM_INSTR <= MEM_DEPTH)
// Ports
//   clk            : in  1  - single clock, rising edge
//   rst            : in  1  - synchronous active-high reset
//   instr_ready    : in  1  - consumer accepts instr this cycle
//   redirect_valid : in  1  - consumer requests a PC change
//   redirect_pc    : in  32 - redirect byte address (bits [1:0] ignored)
//   instr_valid    : out 1  - instr / instr_pc are valid
//   instr          : out 32 - issued instruction word
//   instr_pc       : out 32 - byte address of instr
//   done           : out 1  - program exhausted and output register empty
//   issue_count    : out 16 - completed handshakes, saturating at 16'hFFFF
// ============================================================================
module instr_fetch_unit #(
  parameter int MEM_DEPTH = 32,
  parameter int NUM_INSTR = 22
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        done,
  output logic [15:0] issue_count
);

  // Word-index width of iMem; at least one bit so the slice below is legal.
  localparam int          ADDR_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  // First byte address past the loaded program.
  localparam logic [31:0] LIMIT  = 32'(NUM_INSTR) << 2;

  // Program image. Never written by this logic; loaded by the environment
  // before reset is released, so it is intentionally not reset.
  reg [31:0] iMem [0:MEM_DEPTH-1];

  logic [31:0]       pc;            // next fetch byte address
  logic              xfer;          // handshake completes this cycle
  logic              slot_free;     // output register can take a new word
  logic              fetch_legal;   // pc still inside the program
  logic [ADDR_W-1:0] fetch_idx;
  logic [31:0]       fetch_word;
  logic [31:0]       redirect_aligned;

  assign xfer        = instr_valid & instr_ready;
  assign slot_free   = ~instr_valid | instr_ready;
  assign fetch_legal = (pc < LIMIT);

  // Only consulted when fetch_legal holds, and LIMIT <= MEM_DEPTH*4, so the
  // truncated word index always lands inside iMem when it matters.
  assign fetch_idx   = pc[ADDR_W+1:2];
  assign fetch_word  = iMem[fetch_idx];

  // Word-align the redirect target; the low two bits carry no meaning.
  assign redirect_aligned = redirect_pc & ~32'd3;

  // The fetch state (EMPTY / FULL / DONE) is carried directly by the
  // registered outputs instr_valid and done, so no separate state register
  // is kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= 32'd0;
      instr_valid <= 1'b0;
      instr       <= 32'd0;
      instr_pc    <= 32'd0;
      done        <= 1'b0;
      issue_count <= 16'd0;
    end else begin
      // A handshake counts even when a redirect flushes the slot in the
      // same cycle: the consumer did take the word.
      if (xfer && (issue_count != 16'hFFFF)) begin
        issue_count <= issue_count + 16'd1;
      end

      if (redirect_valid) begin
        // Flush and retarget; the first fetch from the new PC happens on the
        // next edge, which gives the single bubble cycle.
        pc          <= redirect_aligned;
        instr_valid <= 1'b0;
        done        <= 1'b0;
      end else begin
        // done looks at the current register values, so it rises one edge
        // after the output register has drained at the limit.
        done <= ~fetch_legal & ~instr_valid;

        if (slot_free) begin
          if (fetch_legal) begin
            instr       <= fetch_word;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            pc          <= pc + 32'd4;
          end else begin
            instr_valid <= 1'b0;
          end
        end
        // Otherwise the consumer is stalling: hold pc and the output register.
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage for the pr3 single-cycle processor: holds the 32-bit instruction memory `iMem`, maintains the program counter, and presents one instruction at a time to the downstream decode/execute stage over a valid/ready handshake. It accepts PC redirects (branch/jump) from the consumer. It raises `done` once the loaded program has been fully issued, so the bench can dump the register file as soon as `done` is seen rather than after a fixed delay.

## Interface
- `MEM_DEPTH`, 32: number of 32-bit words in `iMem`.
- `NUM_INSTR`, 22: number of valid program words loaded from word 0. Must satisfy NUM_INSTR ≤ MEM_DEPTH.
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `instr_ready`, in, 1: the consumer accepts `instr` this cycle.
- `redirect_valid`, in, 1: the consumer requests a PC change.
- `redirect_pc`, in, 32: byte address of the redirect target. Bits [1:0] are ignored and treated as 0.
- `instr_valid`, out, 1: `instr` and `instr_pc` are valid.
- `instr`, out, 32: the issued instruction word.
- `instr_pc`, out, 32: byte address of `instr`.
- `done`, out, 1: program exhausted and the output register is empty.
- `issue_count`, out, 16: number of completed handshakes. Saturates at 16'hFFFF.
- Memory: `reg [31:0] iMem [0:MEM_DEPTH-1]`. It is not reset. The bench loads it before reset release with `$readmemb("commands.txt", <inst>.iMem)`.

## Operation
- Internal state:
  - `pc` (32 b): next fetch byte address.
  - Output register: `instr_valid`, `instr`, `instr_pc`.
  - `issue_count`.
- Limit: `LIMIT = NUM_INSTR*4`. A fetch is legal iff `pc < LIMIT`.
- Reset (rst=1 at an edge):
  - `pc`, `instr`, `instr_pc`, `issue_count` → 0.
  - `instr_valid`, `done` → 0.
  - Reset has priority over all other inputs.
- Handshake: a transfer occurs in a cycle where `instr_valid && instr_ready`. Each transfer increments `issue_count` (saturating).
- Load condition: when not redirecting and the output register is free (`!instr_valid`, or a transfer is happening this cycle):
  - If the fetch is legal: `instr <= iMem[pc[31:2]]`, `instr_pc <= pc`, `instr_valid <= 1`, `pc <= pc+4`.
  - Otherwise: `instr_valid <= 0`.
- Hold: while `instr_valid && !instr_ready`, the output register and `pc` are frozen.
- Redirect (`redirect_valid=1`, no reset):
  - `pc <= {redirect_pc[31:2],2'b00}`.
  - `instr_valid <= 0` (flush); no fetch in this cycle.
  - A transfer in the same cycle still counts in `issue_count`.
  - The fetch from the new PC occurs on the following edge.
- Redirect to an address ≥ LIMIT: no fetch; `done` rises on the next edge.
- `done` is registered:
  - Asserted the cycle after both `pc ≥ LIMIT` and `instr_valid=0` hold, with no redirect that cycle.
  - Cleared by reset or by any redirect.
- States (encoded by `instr_valid`/`done`):
  - EMPTY: fetch is legal, output empty.
  - FULL: `instr_valid=1`.
  - DONE: `done=1`.
  - Transitions:
    - EMPTY → FULL on a legal fetch.
    - FULL → FULL on transfer plus a legal fetch.
    - FULL → EMPTY/DONE on transfer at the limit.
    - Any state → EMPTY on redirect.
    - DONE → EMPTY on redirect to an address < LIMIT.

## Timing
- Edge E0 is the first edge with rst=0.
  - At E0 the first fetch happens, so `instr_valid=1` with `iMem[0]`, `instr_pc=0` after E0.
  - Fetch latency is 1 cycle.
- With `instr_ready` held at 1, one instruction issues per cycle with no bubbles.
  - The last transfer (`instr_pc=LIMIT-4`) occurs at edge E(NUM_INSTR-1)+1.
  - `instr_valid=0` after that edge; `done=1` one edge later.
- Redirect costs exactly one bubble cycle: `instr_valid=0` for one cycle, then the target instruction appears.
- `iMem` reads are combinational from `pc`, then registered. No read-during-write case exists (`iMem` is never written by RTL).

## Test plan
- Reset/first fetch: load 22 words with `iMem[0]=32'h0000_0020`, hold rst=1 for 2 edges, then release -> after E0: `instr_valid=1`, `instr=32'h0000_0020`, `instr_pc=0`; during reset all outputs are 0.
- Streaming to completion: `instr_ready=1` constant -> 22 transfers with `instr_pc` = 0,4,…,84; `issue_count=22`; `instr_valid=0` after the 22nd transfer; `done=1` exactly one edge later.
- Backpressure: `instr_ready=0` for 3 cycles while `instr_pc=8` -> `instr`/`instr_pc` stable, `pc` stays 12, `issue_count` unchanged; on ready=1 the next value is `instr_pc=12`.
- Redirect with simultaneous transfer: at `instr_pc=16` assert `instr_ready=1` and `redirect_valid=1` with `redirect_pc=32'h0000_0007` -> `issue_count` increments; next cycle `instr_valid=0`; the following cycle `instr_pc=4`.
- Redirect out of range / restart from done: redirect to 32'h100 -> no fetch, `done=1` after the second edge. Then redirect to 0 -> `done=0` next edge, `instr_pc=0` one edge after.
- Reset mid-stream: assert rst while `instr_valid=1`, `instr_ready=0` -> at the next edge all outputs and `issue_count` are 0; after release, fetching restarts at pc=0.
